// File: rtl/serialout_chain.sv
// Serial driver for a daisy-chained 74HC595-style string: streams CHANNELS words of
// WIDTH bits with sclk/sdata framing and a latch strobe, continuously or on change.
module serialout_chain #(
   parameter int WIDTH      = 8,
   parameter int CHANNELS   = 2,
   parameter int CLK_DIV    = 4,
   parameter int MSB_FIRST  = 1,
   parameter int CONTINUOUS = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [CHANNELS*WIDTH-1:0]   data,
   output logic                        sclk,
   output logic                        sdata,
   output logic                        slatch,
   output logic                        busy,
   output logic                        frame_done
);

   localparam int N  = CHANNELS * WIDTH;
   localparam int PW = $clog2(CLK_DIV + 1);
   localparam int BW = $clog2(N + 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_LATCH = 2'd3
   } state_t;

   state_t          state_q;
   logic [N-1:0]    shadow_q;
   logic [N-1:0]    last_sent_q;
   logic            dirty_q;
   logic [BW-1:0]   bit_cnt_q;
   logic [PW-1:0]   phase_q;
   logic            high_q;
   logic            sclk_q;
   logic            sdata_q;
   logic            slatch_q;
   logic            busy_q;
   logic            frame_done_q;
   logic [N-1:0]    ordered;

   // Reorder payload so bit N-1 is always the first bit on the wire; the top
   // channel leads, and LSB-first mode mirrors bits within each word.
   always_comb begin
      ordered = data;
      if (MSB_FIRST == 0) begin
         for (int k = 0; k < CHANNELS; k++) begin
            for (int j = 0; j < WIDTH; j++) begin
               ordered[k*WIDTH + j] = data[k*WIDTH + (WIDTH - 1 - j)];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         shadow_q     <= '0;
         last_sent_q  <= '0;
         dirty_q      <= 1'b1;
         bit_cnt_q    <= '0;
         phase_q      <= '0;
         high_q       <= 1'b0;
         sclk_q       <= 1'b0;
         sdata_q      <= 1'b0;
         slatch_q     <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if ((CONTINUOUS != 0) || dirty_q || (data != last_sent_q)) begin
                  state_q <= S_LOAD;
                  busy_q  <= 1'b1;
               end
            end
            S_LOAD: begin
               // shadow holds the bits still to be sent; the first one goes straight out
               shadow_q    <= ordered << 1;
               sdata_q     <= ordered[N-1];
               last_sent_q <= data;
               dirty_q     <= 1'b0;
               bit_cnt_q   <= BIT_LAST;
               phase_q     <= '0;
               high_q      <= 1'b0;
               sclk_q      <= 1'b0;
               state_q     <= S_SHIFT;
            end
            S_SHIFT: begin
               if (phase_q != PH_LAST) begin
                  phase_q <= phase_q + PW'(1);
               end else begin
                  phase_q <= '0;
                  if (!high_q) begin
                     high_q <= 1'b1;
                     sclk_q <= 1'b1;
                  end else if (bit_cnt_q == '0) begin
                     high_q   <= 1'b0;
                     sclk_q   <= 1'b0;
                     sdata_q  <= 1'b0;
                     slatch_q <= 1'b1;
                     state_q  <= S_LATCH;
                  end else begin
                     high_q    <= 1'b0;
                     sclk_q    <= 1'b0;
                     sdata_q   <= shadow_q[N-1];
                     shadow_q  <= shadow_q << 1;
                     bit_cnt_q <= bit_cnt_q - BW'(1);
                  end
               end
            end
            S_LATCH: begin
               if (phase_q != PH_LAST) begin
                  phase_q <= phase_q + PW'(1);
               end else begin
                  phase_q      <= '0;
                  slatch_q     <= 1'b0;
                  busy_q       <= 1'b0;
                  frame_done_q <= 1'b1;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign sclk       = sclk_q;
   assign sdata      = sdata_q;
   assign slatch     = slatch_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule
